// File: rtl/cordic_fp_pkg.sv
// Shared constants and encodings for the CORDIC floating-point conversion stages.
//   EXP_W / MANT_W / BIAS : IEEE-754 single-precision field widths and exponent bias
//   f2f_state_t           : conversion FSM state encoding
//   pack_ieee()           : assembles {sign, exponent, mantissa} into a 32-bit word
package cordic_fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } f2f_state_t;

    function automatic logic [EXP_W+MANT_W:0] pack_ieee(
        input logic              sign,
        input logic [EXP_W-1:0]  exponent,
        input logic [MANT_W-1:0] mantissa
    );
        return {sign, exponent, mantissa};
    endfunction

endpackage

// File: rtl/cordic_fix2float_regs.sv
// Small storage primitives used by cordic_fix2float.
//   upCounterRE    : up counter with synchronous clear (init) and count enable (en)
//                    ports: clk, rst (async, active-low), init, en, count[WIDTH]
//   register_param : loadable register
//                    ports: clk, rst (async, active-low), load, d[WIDTH], q[WIDTH]
module upCounterRE #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (init) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

module register_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cordic_fix2float.sv
// Converts one signed fixed-point value (Q INT_SIZE.FLOAT_SIZE, two's complement)
// into an IEEE-754 single-precision word. The magnitude is normalised one bit per
// clock, so latency depends on the number of leading zeros.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   in_valid  fix_in is valid            in_ready  high only while idle
//   fix_in    signed fixed-point operand (W = INT_SIZE + FLOAT_SIZE bits)
//   out_valid float_out is valid, held until out_ready
//   out_ready consumer takes float_out   float_out {sign, exp[7:0], mant[22:0]}
//   busy      conversion in progress
// Build option: define CORDIC_F2F_ROUND_EN for round-to-nearest-even mantissa;
// otherwise the bits below the mantissa are truncated.
module cordic_fix2float
    import cordic_fp_pkg::*;
#(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [INT_SIZE+FLOAT_SIZE-1:0] fix_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    float_out,
    output logic                           busy
);

    localparam int W     = INT_SIZE + FLOAT_SIZE;
    localparam int CNT_W = $clog2(W) + 1;
    // Exponent of a value whose leading one already sits in the MSB.
    localparam logic [EXP_W-1:0] EXP_BASE = EXP_W'(W - 1 - FLOAT_SIZE + BIAS);

    f2f_state_t        state, state_nx;
    logic              accept, shift, pack_en;
    logic              sign_q;
    logic [W-1:0]      mag_q, mag_in;
    logic [CNT_W-1:0]  cnt;
    logic [MANT_W-1:0] mant_val;
    logic [EXP_W-1:0]  exp_val;
    logic [31:0]       packed_word;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        shift    = 1'b0;
        pack_en  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0 || mag_q[W-1]) begin
                    state_nx = PACK;
                end else begin
                    shift = 1'b1;
                end
            end
            PACK: begin
                pack_en  = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // ---------------------------------------------------------------- datapath
    // The most negative input negates to itself, which is already the correct
    // unsigned magnitude.
    assign mag_in = fix_in[W-1] ? (~fix_in + W'(1)) : fix_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
        end else if (accept) begin
            sign_q <= fix_in[W-1];
            mag_q  <= mag_in;
        end else if (shift) begin
            mag_q  <= mag_q << 1;
        end
    end

    upCounterRE #(
        .WIDTH(CNT_W)
    ) u_shift_cnt (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .en   (shift),
        .count(cnt)
    );

`ifdef CORDIC_F2F_ROUND_EN
    // Bits below the guard position all feed the sticky bit.
    localparam logic [W-1:0] STICKY_MASK = (W'(1) << (W - MANT_W - 2)) - W'(1);

    logic              guard, sticky, lsb, rnd_inc;
    logic [MANT_W:0]   mant_sum;

    always_comb begin
        guard    = mag_q[W-MANT_W-2];
        lsb      = mag_q[W-MANT_W-1];
        sticky   = |(mag_q & STICKY_MASK);
        rnd_inc  = guard && (sticky || lsb);
        mant_sum = {1'b0, mag_q[W-2 -: MANT_W]} + {{MANT_W{1'b0}}, rnd_inc};
        // A carry out of the mantissa leaves its low bits zero and bumps the exponent.
        mant_val = mant_sum[MANT_W-1:0];
        exp_val  = EXP_BASE - EXP_W'(cnt) + EXP_W'(mant_sum[MANT_W]);
    end
`else
    always_comb begin
        mant_val = mag_q[W-2 -: MANT_W];
        exp_val  = EXP_BASE - EXP_W'(cnt);
    end
`endif

    // Zero magnitude encodes as +0.0 regardless of input sign.
    assign packed_word = (mag_q == '0) ? '0 : pack_ieee(sign_q, exp_val, mant_val);

    register_param #(
        .WIDTH(32)
    ) u_float_reg (
        .clk (clk),
        .rst (rst),
        .load(pack_en),
        .d   (packed_word),
        .q   (float_out)
    );

endmodule

// File: tb/tb_cordic_fix2float.sv
module tb_cordic_fix2float;

    localparam int FLOAT_SIZE = 24;
    localparam int INT_SIZE   = 8;
    localparam int W          = INT_SIZE + FLOAT_SIZE;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fix_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  float_out;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    cordic_fix2float #(
        .FLOAT_SIZE(FLOAT_SIZE),
        .INT_SIZE  (INT_SIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fix_in   (fix_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .float_out(float_out),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference: value = v / 2^FLOAT_SIZE, converted by locating the leading one
    // of |v| and applying the IEEE rounding rule to the discarded remainder.
    function automatic void ref_model(input logic [W-1:0] v, output logic [31:0] f,
                                      output int lat);
        longint m, mant, rem, half;
        int     p, e;
        logic   s;
        s = v[W-1];
        m = s ? ((longint'(1) << W) - longint'(v)) : longint'(v);
        if (m == 0) begin
            f   = 32'h0;
            lat = 2;
            return;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        lat = (W - 1 - p) + 2;
        e   = p - FLOAT_SIZE + 127;
        if (p >= 23) begin
            mant = m >> (p - 23);
            rem  = m - (mant << (p - 23));
        end else begin
            mant = m << (23 - p);
            rem  = 0;
        end
`ifdef CORDIC_F2F_ROUND_EN
        if (p >= 24) begin
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && mant[0])) mant++;
        end
`else
        half = rem;
`endif
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e++;
        end
        f = {s, 8'(e), 23'(mant)};
    endfunction

    // One full transaction: accept, latency, result, hold in DONE, release.
    task automatic do_conv(input logic [W-1:0] v, input int unsigned hold,
                           input logic [31:0] exp_f, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        fix_in    = v;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        fix_in = $urandom;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".float"}, float_out, exp_f);
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            fix_in   = $urandom;
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_float"}, float_out, exp_f);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        // Release with in_valid high: must not be taken on the same edge.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".release_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic model_conv(input logic [W-1:0] v, input int unsigned hold, input string tag);
        logic [31:0] f;
        int          lat;
        ref_model(v, f, lat);
        do_conv(v, hold, f, lat, tag);
    endtask

    initial begin
        logic [W-1:0] v;
        rst       = 1'b0;
        in_valid  = 1'b0;
        fix_in    = '0;
        out_ready = 1'b0;
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.float_out", float_out, 32'h0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        do_conv(32'h0100_0000, 0, 32'h3F80_0000, 9, "one");
        do_conv(32'hFF00_0000, 1, 32'hBF80_0000, 9, "minus_one");
        do_conv(32'h8000_0000, 0, 32'hC300_0000, 2, "minus_128");
        do_conv(32'h0000_0000, 0, 32'h0000_0000, 2, "zero");
        do_conv(32'h0000_0001, 0, 32'h3380_0000, 33, "lsb");
`ifdef CORDIC_F2F_ROUND_EN
        do_conv(32'h7FFF_FFFF, 0, 32'h4300_0000, 3, "max_pos");
`else
        do_conv(32'h7FFF_FFFF, 0, 32'h42FF_FFFF, 3, "max_pos");
`endif
        do_conv(32'h0100_0000, 10, 32'h3F80_0000, 9, "stall");

        // Abort a conversion of fix_in=1 part-way through normalisation.
        @(negedge clk);
        in_valid = 1'b1;
        fix_in   = 32'h0000_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.float_out", float_out, 32'h0);
        check("abort.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_conv(32'h0000_0001, 0, 32'h3380_0000, 33, "after_abort");

        // Randomised operands spread across all magnitudes and both signs.
        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = v >> $urandom_range(0, 31);
                1: v = -(v >> $urandom_range(0, 31));
                2: v = v | 32'h0000_00FF;
                default: ;
            endcase
            model_conv(v, $urandom_range(0, 3), "rand");
        end
        model_conv(32'h00FF_FFFF, 0, "near_one");
        model_conv(32'h0000_0180, 1, "small");
        model_conv(32'hFFFF_FFFF, 0, "minus_lsb");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
